// File: rtl/downscale_block_16_if.sv
// Sample/result bundle between the softmax scoring stage, the downscale
// stage and the exponent stage.
interface downscale_block_16_if #(
    parameter int DATA_SIZE = 16
);
    logic [DATA_SIZE-1:0] downscale_data_i;
    logic                 downscale_data_valid_i;
    logic                 downscale_ready_o;
    logic [DATA_SIZE-1:0] downscale_data_o;
    logic                 downscale_data_valid_o;
    logic                 downscale_done_o;

    modport slave (
        input  downscale_data_i,
        input  downscale_data_valid_i,
        output downscale_ready_o,
        output downscale_data_o,
        output downscale_data_valid_o,
        output downscale_done_o
    );

    modport master (
        output downscale_data_i,
        output downscale_data_valid_i,
        input  downscale_ready_o,
        input  downscale_data_o,
        input  downscale_data_valid_o,
        input  downscale_done_o
    );
endinterface

// File: rtl/downscale_block_16.sv
// Softmax max-subtract stage: buffers a vector, tracks its maximum, then streams x_i - max.
// Optional macro DOWNSCALE_SAT_EN saturates differences below -32767/256 to 16'h8001.
module downscale_block_16 #(
    parameter int DATA_SIZE  = 16,
    parameter int VECTOR_LEN = 8,
    parameter int ADDR_SIZE  = $clog2(VECTOR_LEN)
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    downscale_block_16_if.slave  ds
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(VECTOR_LEN - 1);
    localparam logic [ADDR_SIZE-1:0] IDX_ONE  = ADDR_SIZE'(1);

`ifdef DOWNSCALE_SAT_EN
    localparam logic signed [DATA_SIZE:0] SAT_LIMIT = {2'b11, {(DATA_SIZE-2){1'b0}}, 1'b1};
    localparam logic [DATA_SIZE-1:0]      SAT_CODE  = {1'b1, {(DATA_SIZE-2){1'b0}}, 1'b1};
`endif

    // Difference is formed one bit wider so the out-of-range case is visible.
    function automatic logic [DATA_SIZE-1:0] sub_max(
        input logic [DATA_SIZE-1:0] x,
        input logic [DATA_SIZE-1:0] m
    );
`ifdef DOWNSCALE_SAT_EN
        logic signed [DATA_SIZE:0] diff;
        diff = $signed({x[DATA_SIZE-1], x}) - $signed({m[DATA_SIZE-1], m});
        if (diff < SAT_LIMIT) begin
            return SAT_CODE;
        end else begin
            return diff[DATA_SIZE-1:0];
        end
`else
        return x - m;
`endif
    endfunction

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   load_cnt_q, load_cnt_d;
    logic [ADDR_SIZE-1:0]   sub_cnt_q, sub_cnt_d;
    logic [DATA_SIZE-1:0]   max_q, max_d;
    logic [DATA_SIZE-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   buf_we_s;
    logic [DATA_SIZE-1:0]   buf_q [VECTOR_LEN];

    // Next-state, counter, max tracking and output computation.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        sub_cnt_d  = sub_cnt_q;
        max_d      = max_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        buf_we_s   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (ds.downscale_data_valid_i) begin
                    buf_we_s = 1'b1;
                    if (load_cnt_q == '0) begin
                        max_d = ds.downscale_data_i;
                    end else if ($signed(ds.downscale_data_i) > $signed(max_q)) begin
                        max_d = ds.downscale_data_i;
                    end else begin
                        max_d = max_q;
                    end
                    if (load_cnt_q == LAST_IDX) begin
                        load_cnt_d = '0;
                        sub_cnt_d  = '0;
                        state_d    = ST_SUB;
                    end else begin
                        load_cnt_d = load_cnt_q + IDX_ONE;
                    end
                end else begin
                    buf_we_s = 1'b0;
                end
            end
            ST_SUB: begin
                data_d  = sub_max(buf_q[sub_cnt_q], max_q);
                valid_d = 1'b1;
                if (sub_cnt_q == LAST_IDX) begin
                    sub_cnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    sub_cnt_d = sub_cnt_q + IDX_ONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            sub_cnt_q  <= '0;
            max_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            max_q      <= max_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    // Sample buffer; contents are don't-care after reset.
    always_ff @(posedge clock_i) begin
        if (buf_we_s) begin
            buf_q[load_cnt_q] <= ds.downscale_data_i;
        end
    end

    assign ds.downscale_ready_o      = (state_q == ST_LOAD);
    assign ds.downscale_data_o       = data_q;
    assign ds.downscale_data_valid_o = valid_q;
    assign ds.downscale_done_o       = done_q;

endmodule

// File: tb/tb_downscale_block_16.sv
// Self-checking bench for downscale_block_16 (vector_len = 4): directed table,
// multi-cycle corner sequences and randomized vectors against a reference model.
module tb_downscale_block_16;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    downscale_block_16_if #(.DATA_SIZE(16)) ds_if ();

    downscale_block_16 #(
        .DATA_SIZE (16),
        .VECTOR_LEN(N)
    ) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .ds       (ds_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [N-1:0][15:0] vec_t;

    typedef struct {
        string tag;
        vec_t  in;
        vec_t  exp;
        int    gap;
        bit    ign;
    } rec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: max by plain integer comparison, then signed difference.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   mx;
        int   d;
        mx = int'($signed(v[0]));
        for (int i = 1; i < N; i++) begin
            if (int'($signed(v[i])) > mx) mx = int'($signed(v[i]));
        end
        for (int i = 0; i < N; i++) begin
            d = int'($signed(v[i])) - mx;
`ifdef DOWNSCALE_SAT_EN
            if (d < -32767) r[i] = 16'h8001;
            else r[i] = 16'(d);
`else
            r[i] = 16'(d);
`endif
        end
        return r;
    endfunction

    // Loads one vector (optionally gapped), then checks the full output timeline.
    task automatic run_vec(input string tag, input vec_t v, input vec_t e, input int gap, input bit ign);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                ds_if.downscale_data_valid_i = 1'b0;
                ds_if.downscale_data_i       = 16'($urandom);
                @(posedge clk); #1;
            end
            chk({tag, " ready_load"}, {15'd0, ds_if.downscale_ready_o}, 16'd1);
            ds_if.downscale_data_valid_i = 1'b1;
            ds_if.downscale_data_i       = v[i];
            @(posedge clk); #1;
        end
        ds_if.downscale_data_valid_i = ign;
        ds_if.downscale_data_i       = ign ? 16'h7FFF : 16'h0000;
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s valid%0d", tag, k), {15'd0, ds_if.downscale_data_valid_o}, 16'd1);
            chk($sformatf("%s data%0d", tag, k), ds_if.downscale_data_o, e[k]);
            chk($sformatf("%s ready_sub%0d", tag, k), {15'd0, ds_if.downscale_ready_o}, 16'd0);
            chk($sformatf("%s done_early%0d", tag, k), {15'd0, ds_if.downscale_done_o}, 16'd0);
        end
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, {15'd0, ds_if.downscale_done_o}, 16'd1);
        chk({tag, " valid_at_done"}, {15'd0, ds_if.downscale_data_valid_o}, 16'd0);
        ds_if.downscale_data_valid_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " done_clear"}, {15'd0, ds_if.downscale_done_o}, 16'd0);
        chk({tag, " ready_back"}, {15'd0, ds_if.downscale_ready_o}, 16'd1);
        chk({tag, " valid_idle"}, {15'd0, ds_if.downscale_data_valid_o}, 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " rst_data"}, ds_if.downscale_data_o, 16'h0000);
        chk({tag, " rst_valid"}, {15'd0, ds_if.downscale_data_valid_o}, 16'd0);
        chk({tag, " rst_done"}, {15'd0, ds_if.downscale_done_o}, 16'd0);
        chk({tag, " rst_ready"}, {15'd0, ds_if.downscale_ready_o}, 16'd1);
    endtask

    rec_t tbl [5];
    vec_t basic_in;
    vec_t basic_exp;
    vec_t rv;

    initial begin
        checks = 0;
        errors = 0;
        ds_if.downscale_data_i       = 16'h0000;
        ds_if.downscale_data_valid_i = 1'b0;

        basic_in  = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
        basic_exp = {16'hFE80, 16'hFD00, 16'h0000, 16'hFF00};
        tbl[0] = '{"basic", basic_in, basic_exp, 0, 1'b0};
`ifdef DOWNSCALE_SAT_EN
        tbl[1] = '{"extreme", {16'h0000, 16'h0000, 16'h8000, 16'h7F00},
                   {16'h8100, 16'h8100, 16'h8001, 16'h0000}, 0, 1'b0};
`else
        tbl[1] = '{"extreme", {16'h0000, 16'h0000, 16'h8000, 16'h7F00},
                   {16'h8100, 16'h8100, 16'h0100, 16'h0000}, 0, 1'b0};
`endif
        tbl[2] = '{"equal_neg", {16'hF000, 16'hF000, 16'hF000, 16'hF000},
                   {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 1'b0};
        tbl[3] = '{"gapped", basic_in, basic_exp, 1, 1'b0};
        tbl[4] = '{"ignored", basic_in, basic_exp, 0, 1'b1};

        rst_n = 1'b0;
        #12;
        check_reset_outputs("init");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            run_vec(tbl[t].tag, tbl[t].in, tbl[t].exp, tbl[t].gap, tbl[t].ign);
        end
        run_vec("after_ignored", {16'h0300, 16'h0010, 16'hFFFF, 16'h8000},
                model({16'h0300, 16'h0010, 16'hFFFF, 16'h8000}), 0, 1'b0);

        // Mid-load reset: two samples in, then asynchronous reset.
        for (int i = 0; i < 2; i++) begin
            ds_if.downscale_data_valid_i = 1'b1;
            ds_if.downscale_data_i       = 16'h7000;
            @(posedge clk); #1;
        end
        ds_if.downscale_data_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec("post_midload", basic_in, basic_exp, 0, 1'b0);

        // Reset while streaming results.
        for (int i = 0; i < N; i++) begin
            ds_if.downscale_data_valid_i = 1'b1;
            ds_if.downscale_data_i       = 16'h1234;
            @(posedge clk); #1;
        end
        ds_if.downscale_data_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsub");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec("post_midsub", basic_in, basic_exp, 0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: rv[i] = 16'h8000 | 16'($urandom_range(0, 255));
                    1: rv[i] = 16'h7F00 | 16'($urandom_range(0, 255));
                    default: rv[i] = 16'($urandom);
                endcase
            end
            run_vec($sformatf("rand%0d", r), rv, model(rv), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/downscale_block_16.md
# downscale_block_16

Max-subtract (downscale) stage of the 16-bit softmax datapath, sitting directly upstream of the exponent stage. Buffers one vector of signed 1.7.8 scores, tracks the running maximum during load, then streams x_i − max (always ≤ 0) one element per cycle to the exponent stage. Emits a one-cycle done pulse after the last element, which feeds the exponent stage's downscale-done input.

## Interface
- data_size, 16: element width, signed fixed point 1.7.8.
- vector_len, 8: elements per vector, ≥2.
- addr_size, $clog2(vector_len): buffer index and counter width.

- clock_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  reset; asynchronous, active-low.
- downscale_data_i  in  data_size  input score, signed 1.7.8.
- downscale_data_valid_i  in  1  input sample present.
- downscale_ready_o  out  1  high while accepting samples.
- downscale_data_o  out  data_size  x_i − max, signed 1.7.8; feeds the exponent stage's data input.
- downscale_data_valid_o  out  1  downscale_data_o valid this cycle.
- downscale_done_o  out  1  one-cycle pulse after the last element of a vector.

## Operation
- States: LOAD, SUB, DONE. Reset enters LOAD.
- LOAD:
  - downscale_ready_o = 1.
  - A sample is accepted when downscale_data_valid_i is high: it is written to buffer[load_cnt] and load_cnt increments.
  - Max register: the first sample (load_cnt==0) loads max unconditionally; later samples replace max when sample > max (signed compare).
  - Accepting sample vector_len−1 clears load_cnt, moves to SUB, and sets sub_cnt=0. Max includes that last sample.
- SUB:
  - downscale_ready_o = 0; downscale_data_valid_i is ignored and nothing is stored.
  - Each cycle: downscale_data_o ← buffer[sub_cnt] − max, valid_o ← 1, sub_cnt increments.
  - After element vector_len−1 is issued, moves to DONE.
- DONE:
  - downscale_done_o ← 1 for exactly one cycle, valid_o ← 0, then returns to LOAD.
- Arithmetic: the difference is formed in data_size+1 bits. The result is always ≤ 0. Out-of-range handling is set by the Configuration section.
- No backpressure: the downstream stage always accepts.
- Reset mid-operation: the partial vector is discarded; counters, max, state and outputs return to reset values. Buffer contents need not be cleared.

## Timing
- Reset values:
  - downscale_data_o = 0, downscale_data_valid_o = 0, downscale_done_o = 0.
  - downscale_ready_o = 1 (state LOAD).
- All outputs are registered. downscale_ready_o is a decode of the state register.
- If the last sample is accepted at edge T:
  - Edges T+1..T+vector_len carry elements 0..vector_len−1 with valid_o = 1 on consecutive cycles.
  - Edge T+vector_len+1: valid_o = 0, done_o = 1.
  - Edge T+vector_len+2: done_o = 0, ready_o = 1.
- Gaps in downscale_data_valid_i during LOAD only stall loading; the result is identical to contiguous input.
- Throughput: one vector per (vector_len load cycles + vector_len + 1) cycles minimum.

## Configuration
- DOWNSCALE_SAT_EN defined: a difference below −32767/256 saturates to 16'h8001. This code makes the exponent stage's negated value 16'h7FFF, whose out-of-range path produces 0.
- DOWNSCALE_SAT_EN undefined: the low data_size bits of the difference are output unchanged, so out-of-range differences wrap.

## Test plan
- Basic vector (vector_len=4): inputs 16'h0100, 16'h0200, 16'hFF00, 16'h0080 → max 16'h0200 → outputs 16'hFF00, 16'h0000, 16'hFD00, 16'hFE80 on four consecutive cycles, then done_o for one cycle, then ready_o high.
- Range extreme: inputs 16'h7F00, 16'h8000, 16'h0000, 16'h0000.
  - With DOWNSCALE_SAT_EN: outputs 16'h0000, 16'h8001, 16'h8100, 16'h8100.
  - Without it: the second output is 16'h0100.
- All-equal negatives: four samples of 16'hF000 → four outputs of 16'h0000; max correct when no sample exceeds the first.
- Gapped input: the basic vector with valid_i high every other cycle → identical outputs and the same latency counted from the last accepted sample.
- Ignored input: drive valid_i=1, data 16'h7FFF throughout SUB and DONE → outputs unchanged, no extra sample stored, next vector processed correctly.
- Mid-load reset: assert reset_n_i low after 2 of 4 samples → all outputs 0 immediately. After release, a fresh basic vector yields exactly the basic-vector outputs.
